// File: rtl/gshare_if.sv
// Fetch/resolve-side bundle of the gshare predictor: request and update strobes
// from the pipeline, readiness and prediction back from the predictor.
interface gshare_if #(
  parameter int HIST_BITS = 4
);
  logic                 request;
  logic [HIST_BITS-1:0] req_pc;
  logic                 result;
  logic [HIST_BITS-1:0] res_pc;
  logic                 taken;
  logic                 ready;
  logic                 pred_valid;
  logic                 prediction;
  logic                 pred_strong;

  modport master (
    output request, req_pc, result, res_pc, taken,
    input  ready, pred_valid, prediction, pred_strong
  );

  modport slave (
    input  request, req_pc, result, res_pc, taken,
    output ready, pred_valid, prediction, pred_strong
  );
endinterface

// File: rtl/gshare_predictor.sv
// Global-history branch predictor with saturating counters, optional gshare
// (PC XOR history) indexing and a post-reset sweep that loads weakly-not-taken.
module gshare_predictor #(
  parameter int HIST_BITS = 4,
  parameter int CTR_BITS  = 2,
  parameter int GSHARE    = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  gshare_if.slave  bus
);
  localparam int DEPTH = 1 << HIST_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};

  typedef enum logic {INIT, RUN} state_t;

  state_t               state_reg;
  logic [HIST_BITS-1:0] init_ptr_reg;
  logic [HIST_BITS-1:0] hist_reg;
  logic                 ready_reg;
  logic                 pred_valid_reg;
  logic                 prediction_reg;
  logic                 pred_strong_reg;

  logic [CTR_BITS-1:0]  ctr_mem [DEPTH];

  logic [HIST_BITS-1:0] req_idx;
  logic [HIST_BITS-1:0] res_idx;
  logic [CTR_BITS-1:0]  req_ctr;
  logic [CTR_BITS-1:0]  res_ctr;
  logic [CTR_BITS-1:0]  upd_ctr;
  logic                 wr_en;
  logic [HIST_BITS-1:0] wr_idx;
  logic [CTR_BITS-1:0]  wr_data;

  generate
    if (GSHARE != 0) begin : g_gshare_idx
      assign req_idx = bus.req_pc ^ hist_reg;
      assign res_idx = bus.res_pc ^ hist_reg;
    end else begin : g_hist_idx
      assign req_idx = hist_reg;
      assign res_idx = hist_reg;
    end
  endgenerate

  // Both reads see the table before this edge's write, so a colliding
  // request still observes the pre-update counter.
  assign req_ctr = ctr_mem[req_idx];
  assign res_ctr = ctr_mem[res_idx];

  always_comb begin
    upd_ctr = res_ctr;
    if (bus.taken && (res_ctr != CTR_MAX)) begin
      upd_ctr = res_ctr + CTR_ONE;
    end else if (!bus.taken && (res_ctr != '0)) begin
      upd_ctr = res_ctr - CTR_ONE;
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = res_idx;
    wr_data = upd_ctr;
    if (rst_n) begin
      if (state_reg == INIT) begin
        wr_en   = 1'b1;
        wr_idx  = init_ptr_reg;
        wr_data = CTR_WNT;
      end else if (bus.result) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ctr_mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= INIT;
      init_ptr_reg    <= '0;
      hist_reg        <= '0;
      ready_reg       <= 1'b0;
      pred_valid_reg  <= 1'b0;
      prediction_reg  <= 1'b0;
      pred_strong_reg <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          pred_valid_reg <= 1'b0;
          init_ptr_reg   <= init_ptr_reg + HIST_BITS'(1);
          if (init_ptr_reg == '1) begin
            state_reg <= RUN;
            ready_reg <= 1'b1;
          end
        end
        RUN: begin
          pred_valid_reg <= bus.request;
          if (bus.request) begin
            prediction_reg  <= req_ctr[CTR_BITS-1];
            pred_strong_reg <= (req_ctr == CTR_MAX) || (req_ctr == '0);
          end
          // Newest outcome enters at the MSB.
          if (bus.result) begin
            hist_reg <= {bus.taken, hist_reg[HIST_BITS-1:1]};
          end
        end
        default: state_reg <= INIT;
      endcase
    end
  end

  assign bus.ready       = ready_reg;
  assign bus.pred_valid  = pred_valid_reg;
  assign bus.prediction  = prediction_reg;
  assign bus.pred_strong = pred_strong_reg;
endmodule

// File: tb/tb_gshare_predictor.sv
// Drives a history-indexed and a gshare-indexed predictor with the same stimulus
// and scores both against a table-of-integers reference model.
module tb_gshare_predictor;
  localparam int HB    = 4;
  localparam int CB    = 2;
  localparam int DEPTH = 1 << HB;
  localparam int CMAX  = (1 << CB) - 1;
  localparam int WNT   = (1 << (CB - 1)) - 1;
  localparam int HALF  = 1 << (CB - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gshare_if #(.HIST_BITS(HB)) if0 ();
  gshare_if #(.HIST_BITS(HB)) if1 ();

  gshare_predictor #(.HIST_BITS(HB), .CTR_BITS(CB), .GSHARE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  gshare_predictor #(.HIST_BITS(HB), .CTR_BITS(CB), .GSHARE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one counter table, history and init countdown per DUT.
  int m_ctr [2][DEPTH];
  int m_hist [2];
  int m_cnt [2];
  bit m_ready [2];
  bit held_pred [2];
  bit held_strong [2];
  logic [1:0] q0 [$];
  logic [1:0] q1 [$];
  bit mon_en = 1'b0;

  task automatic check_val(input string name, input int g, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0d want %0d", name, g, $time, act, exp);
    end
  endtask

  task automatic model_step(input int g, input bit rq, input int rpc, input bit rs, input int spc, input bit tk, input bit rn);
    int ri, ui, c;
    if (!rn) begin
      m_hist[g] = 0;
      m_cnt[g] = 0;
      m_ready[g] = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_ctr[g][i] = WNT;
      held_pred[g] = 1'b0;
      held_strong[g] = 1'b0;
    end else if (!m_ready[g]) begin
      m_cnt[g]++;
      if (m_cnt[g] == DEPTH) m_ready[g] = 1'b1;
    end else begin
      ri = (g == 1) ? (rpc ^ m_hist[g]) : m_hist[g];
      ui = (g == 1) ? (spc ^ m_hist[g]) : m_hist[g];
      if (rq) begin
        c = m_ctr[g][ri];
        if (g == 0) q0.push_back({c >= HALF, (c == CMAX) || (c == 0)});
        else        q1.push_back({c >= HALF, (c == CMAX) || (c == 0)});
      end
      if (rs) begin
        c = m_ctr[g][ui];
        m_ctr[g][ui] = tk ? ((c < CMAX) ? c + 1 : CMAX) : ((c > 0) ? c - 1 : 0);
        m_hist[g] = (int'(tk) * (1 << (HB - 1))) + (m_hist[g] / 2);
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit rq, input int rpc, input bit rs, input int spc, input bit tk, input bit rn);
    rst_n = rn;
    if0.request = rq; if0.req_pc = HB'(rpc); if0.result = rs; if0.res_pc = HB'(spc); if0.taken = tk;
    if1.request = rq; if1.req_pc = HB'(rpc); if1.result = rs; if1.res_pc = HB'(spc); if1.taken = tk;
    for (int g = 0; g < 2; g++) model_step(g, rq, rpc, rs, spc, tk, rn);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic expect_out(input string name, input int g, input bit p, input bit s);
    if (g == 0) begin
      check_val({name, "_valid"}, 0, 4'(if0.pred_valid), 4'd1);
      check_val({name, "_pred"}, 0, 4'(if0.prediction), 4'(p));
      check_val({name, "_strong"}, 0, 4'(if0.pred_strong), 4'(s));
    end else begin
      check_val({name, "_valid"}, 1, 4'(if1.pred_valid), 4'd1);
      check_val({name, "_pred"}, 1, 4'(if1.prediction), 4'(p));
      check_val({name, "_strong"}, 1, 4'(if1.pred_strong), 4'(s));
    end
  endtask

  task automatic mon(input int g, input logic rdy, input logic pv, input logic p, input logic s);
    logic [1:0] e;
    check_val("ready", g, 4'(rdy), 4'(m_ready[g]));
    if (pv === 1'b1) begin
      checks++;
      if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
        errors++;
        $display("FAIL unexpected_pred_valid dut%0d t=%0t: got pulse want none", g, $time);
      end else begin
        e = (g == 0) ? q0.pop_front() : q1.pop_front();
        held_pred[g] = e[1];
        held_strong[g] = e[0];
        check_val("sb_pred", g, 4'(p), 4'(e[1]));
        check_val("sb_strong", g, 4'(s), 4'(e[0]));
      end
    end else begin
      check_val("pred_valid", g, 4'(pv), 4'd0);
      check_val("held_pred", g, 4'(p), 4'(held_pred[g]));
      check_val("held_strong", g, 4'(s), 4'(held_strong[g]));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        mon(0, if0.ready, if0.pred_valid, if0.prediction, if0.pred_strong);
        mon(1, if1.ready, if1.pred_valid, if1.prediction, if1.pred_strong);
      end
    end
  end

  initial begin
    if0.request = 0; if0.req_pc = '0; if0.result = 0; if0.res_pc = '0; if0.taken = 0;
    if1.request = 0; if1.req_pc = '0; if1.result = 0; if1.res_pc = '0; if1.taken = 0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;

    // Init sweep: ready low for DEPTH cycles; a request inside it is dropped.
    for (int i = 1; i <= DEPTH; i++) begin
      step(i == 5, 0, i == 7, 0, 1, 1);
      if (i == 5) check_val("init_req_ignored", 0, 4'(if0.pred_valid), 4'd0);
      if (i == DEPTH - 1) check_val("ready_low_last", 0, 4'(if0.ready), 4'd0);
      if (i == DEPTH) check_val("ready_high", 0, 4'(if0.ready), 4'd1);
    end
    step(1, 0, 0, 0, 0, 1);
    expect_out("first_req", 0, 0, 0);

    repeat (6) step(0, 0, 1, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1);
    expect_out("trained_15", 0, 1, 1);

    repeat (3) step(0, 0, 1, 0, 1, 1);
    step(0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    expect_out("idx7_after_nt", 0, 0, 0);

    // Fresh table, then gshare training at PC 0101.
    step(0, 0, 0, 0, 0, 0);
    idle(DEPTH);
    step(0, 0, 1, 5, 1, 1);
    step(0, 0, 1, 5, 1, 1);
    step(1, 9, 0, 0, 0, 1);
    expect_out("gshare_hit", 1, 1, 0);
    expect_out("hist_only_idx12", 0, 0, 0);

    // Collision of request and update at index 15.
    step(0, 0, 1, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1);
    step(1, 0, 1, 0, 1, 1);
    expect_out("collide_old", 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    expect_out("collide_new", 0, 1, 0);

    // Mid-stream reset with a request pending clears everything.
    step(1, 0, 0, 0, 0, 0);
    check_val("rst_ready", 0, 4'(if0.ready), 4'd0);
    check_val("rst_valid", 0, 4'(if0.pred_valid), 4'd0);
    check_val("rst_pred", 0, 4'(if0.prediction), 4'd0);
    idle(DEPTH);
    step(1, 0, 0, 0, 0, 1);
    expect_out("post_reset", 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 2) != 0, $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);
    end
    idle(3);
    check_val("q0_drained", 0, 4'(q0.size() != 0), 4'd0);
    check_val("q1_drained", 1, 4'(q1.size() != 0), 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
